uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmit serializer among N requesters using round-robin arbitration.
- Sequences each frame as start bit, 8 data bits LSB first, optional parity, then stop bit, from an internal baud divider.
- The frame format matches the team's my_UART_RX receiver: 8 data bits, even parity by default, 1 stop bit.
- Sits between on-chip message sources (status, debug, echo) and the board TXD pin.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 9_600, line bit rate. DIV = CLK_FREQ / BAUD_RATE (integer division) gives clocks per bit; DIV must be at least 2.
- N_REQ, 4, number of requesters, minimum 2.
- PARITY_EN, 1, 1 = send a parity bit, 0 = no parity bit.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity.

Ports:
- CLK  in  1  system clock; all logic rising-edge.
- RST  in  1  asynchronous, active-high reset.
- REQ  in  N_REQ  per-requester transmit request; level-held until that requester's ACK.
- DATA  in  8*N_REQ  byte for requester i on DATA[8*i+7:8*i]; must be stable while REQ[i]=1.
- ACK  out  N_REQ  one-cycle pulse: requester's byte has been captured.
- GRANT_ID  out  clog2(N_REQ)  index of the requester currently being transmitted.
- BUSY  out  1  high while a frame is in progress.
- FRAME_DONE  out  1  one-cycle pulse on the last clock of the stop bit.
- TXD  out  1  serial line; idles high.

Behaviour:
- Reset values (async, immediate): TXD=1, ACK=0, BUSY=0, FRAME_DONE=0, GRANT_ID=0, state=IDLE, baud counter=0, bit counter=0, round-robin pointer last=N_REQ-1 (requester 0 has top priority first).
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: TXD=1, BUSY=0.
  - If any REQ bit is set, pick the first set index searching from last+1 upward, with wrap-around.
  - On the next edge: latch that DATA byte into the shift register; compute parity (XOR of the byte, inverted if PARITY_ODD); set last and GRANT_ID to the index; go to START.
  - In that same cycle ACK[index]=1 for exactly 1 cycle, and BUSY=1.
- Latency: REQ sampled high in IDLE at cycle t gives ACK, BUSY and TXD=0 at cycle t+1.
- Each bit state holds TXD for exactly DIV clocks.
  - The baud counter resets to 0 on entry to START and counts 0..DIV-1 per bit.
  - No free-running tick, so there is no phase jitter on the first bit.
- DATA sequence:
  - TXD = shift register bit 0 for each bit; shift right after each bit.
  - The 3-bit counter advances 0..7; after bit 7 go to PARITY if PARITY_EN=1, otherwise to STOP.
- PARITY: TXD = latched parity bit for DIV clocks, then STOP.
- STOP:
  - TXD=1 for DIV clocks.
  - FRAME_DONE=1 on the final clock (baud counter = DIV-1).
  - Then IDLE.
- Frame length: (11 if PARITY_EN else 10) × DIV clocks from the START entry to the end of STOP.
- Back-to-back frames: IDLE lasts exactly 1 clock when REQ is pending, so the gap between frames is 1 clock of TXD=1.
- REQ changes mid-frame:
  - The transmission is unaffected, since the data was latched at ACK.
  - New requests are held pending and arbitrated in the next IDLE.
- A requester that keeps REQ high after its ACK is treated as a new request. The round-robin pointer guarantees other pending requesters are served first (max wait of N_REQ-1 frames).
- Simultaneous REQ on all lines: served in strict rotation starting after last.
- GRANT_ID holds its value through IDLE until the next grant.
- Reset asserted mid-frame: outputs return to their reset values immediately. The partial frame is abandoned, with no ACK re-pulse and no FRAME_DONE.

Test Plan:
1. Parameters CLK_FREQ=153_600, BAUD_RATE=9_600 (DIV=16). REQ[0]=1, DATA[7:0]=0x41 →
   - ACK[0] pulses once.
   - TXD = 0,1,0,0,0,0,0,1,0,0(parity),1, each bit for 16 clocks.
   - BUSY high for 176 clocks; FRAME_DONE on clock 176.
2. After reset, REQ=4'b1111 with bytes 0x10,0x11,0x12,0x13, each REQ dropped on its ACK →
   - Frames sent in order 0,1,2,3.
   - GRANT_ID = 0,1,2,3.
   - 1-clock TXD=1 gap between frames.
3. REQ[0] held permanently, REQ[2] asserted during requester 0's frame → next frame is requester 2, then 0 again; requester 0 never transmits twice in a row while REQ[2] is pending.
4. Requester 1 granted, then REQ[1] dropped and DATA[15:8] changed mid-frame → full 11-bit frame of the originally latched byte; no extra ACK.
5. Data 0x07:
   - Default parameters → parity bit 1.
   - PARITY_ODD=1 → parity bit 0.
   - PARITY_EN=0 → 10-bit frame of 160 clocks with no parity bit.
6. RST pulsed during data bit 3 → TXD=1, BUSY=0, ACK=0 in the same cycle. After release with REQ=4'b1010, requester 1 is granted first.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bundle for the shared UART transmitter: request/byte in,
// acknowledge, grant index, frame status and the serial line out.
interface uart_tx_arbiter_if #(
    parameter int unsigned N_REQ = 4
);
    localparam int unsigned ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]   REQ;
    logic [8*N_REQ-1:0] DATA;
    logic [N_REQ-1:0]   ACK;
    logic [ID_W-1:0]    GRANT_ID;
    logic               BUSY;
    logic               FRAME_DONE;
    logic               TXD;

    modport master (
        output REQ, DATA,
        input  ACK, GRANT_ID, BUSY, FRAME_DONE, TXD
    );

    modport slave (
        input  REQ, DATA,
        output ACK, GRANT_ID, BUSY, FRAME_DONE, TXD
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding a single UART serializer: start, 8 data bits
// LSB first, optional parity, one stop bit, each bit DIV clocks long.
module uart_tx_arbiter #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD_RATE  = 9_600,
    parameter int unsigned N_REQ      = 4,
    parameter bit          PARITY_EN  = 1'b1,
    parameter bit          PARITY_ODD = 1'b0
) (
    input logic              CLK,
    input logic              RST,
    uart_tx_arbiter_if.slave bus
);
    localparam int unsigned DIV   = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned CW    = ID_W + 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
    localparam logic [ID_W-1:0]  ID_LAST   = ID_W'(N_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               parity_q, parity_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               txd_q, txd_d;

    logic [7:0]         req_byte [N_REQ];
    logic               found_c;
    logic [ID_W-1:0]    pick_c;
    logic [CW-1:0]      cand_c;
    logic [ID_W-1:0]    cand_idx_c;
    logic               bit_end_c;

    for (genvar g = 0; g < N_REQ; g++) begin : g_byte
        assign req_byte[g] = bus.DATA[8*g +: 8];
    end

    // First pending requester after the previous winner, wrapping around.
    always_comb begin
        found_c    = 1'b0;
        pick_c     = '0;
        cand_c     = '0;
        cand_idx_c = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand_c = CW'(last_q) + CW'(k);
            if (cand_c >= CW'(N_REQ)) begin
                cand_c = cand_c - CW'(N_REQ);
            end
            cand_idx_c = ID_W'(cand_c);
            if (!found_c && bus.REQ[cand_idx_c]) begin
                found_c = 1'b1;
                pick_c  = cand_idx_c;
            end
        end
    end

    assign bit_end_c = (baud_q == BAUD_LAST);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        last_d   = last_q;
        grant_d  = grant_q;
        ack_d    = '0;

        unique case (state_q)
            S_IDLE: begin
                if (found_c) begin
                    state_d        = S_START;
                    baud_d         = '0;
                    bit_d          = '0;
                    shift_d        = req_byte[pick_c];
                    parity_d       = (^req_byte[pick_c]) ^ PARITY_ODD;
                    last_d         = pick_c;
                    grant_d        = pick_c;
                    ack_d[pick_c]  = 1'b1;
                end
            end
            S_START: begin
                if (bit_end_c) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end_c) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = PARITY_EN ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end_c) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_end_c) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Per-bit counter restarts at every bit boundary; idle keeps it at zero.
        if (state_q != S_IDLE) begin
            baud_d = bit_end_c ? '0 : baud_q + CNT_W'(1);
        end

        // Outputs are registered, so decode them from the next-state values.
        unique case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
            S_PARITY: txd_d = parity_d;
            default:  txd_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_STOP) && (baud_d == BAUD_LAST);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            last_q   <= ID_LAST;
            grant_q  <= '0;
            ack_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            txd_q    <= txd_d;
        end
    end

    assign bus.ACK        = ack_q;
    assign bus.GRANT_ID   = grant_q;
    assign bus.BUSY       = busy_q;
    assign bus.FRAME_DONE = done_q;
    assign bus.TXD        = txd_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Three arbiters (even parity, odd parity, no parity) at DIV=16 against a
// frame-level round-robin model; a negedge monitor checks every line clock.
module tb_uart_tx_arbiter;
    localparam int N   = 4;
    localparam int DIV = 16;
    localparam int NL  = 3;

    typedef struct {
        int         id;
        logic [7:0] data;
        int         at;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    logic [N-1:0]   req_a  [NL];
    logic [8*N-1:0] data_a [NL];
    logic [N-1:0]   ack_a  [NL];
    logic [1:0]     gid_a  [NL];
    logic           busy_a [NL];
    logic           done_a [NL];
    logic           txd_a  [NL];

    for (genvar g = 0; g < NL; g++) begin : g_lane
        uart_tx_arbiter_if #(.N_REQ(N)) bus_if ();
        assign bus_if.REQ  = req_a[g];
        assign bus_if.DATA = data_a[g];
        assign ack_a[g]    = bus_if.ACK;
        assign gid_a[g]    = bus_if.GRANT_ID;
        assign busy_a[g]   = bus_if.BUSY;
        assign done_a[g]   = bus_if.FRAME_DONE;
        assign txd_a[g]    = bus_if.TXD;

        uart_tx_arbiter #(
            .CLK_FREQ  (153_600),
            .BAUD_RATE (9_600),
            .N_REQ     (N),
            .PARITY_EN (g != 2),
            .PARITY_ODD(g == 1)
        ) u_dut (
            .CLK(CLK),
            .RST(RST),
            .bus(bus_if)
        );
    end

    int checks = 0;
    int errors = 0;

    function automatic int flen(input int l);
        return (l == 2) ? 10 : 11;
    endfunction

    function automatic logic [10:0] frame_bits(input int l, input logic [7:0] d);
        logic p;
        p = (^d) ^ (l == 1);
        if (l == 2) return {2'b11, d, 1'b0};
        return {1'b1, p, d, 1'b0};
    endfunction

    task automatic chk(input int l, input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL lane%0d %s: got %0d required %0d (t=%0t)", l, name, got, want, $time);
        end
    endtask

    // Reference model: a lane is free one idle clock after its last frame,
    // then serves the first pending requester after the previous winner.
    int   cyc = 0;
    int   m_last [NL] = '{default: N-1};
    int   m_next [NL] = '{default: 0};
    exp_t exp_q  [NL][$];

    always @(posedge CLK) begin
        int   pick;
        exp_t e;
        cyc = cyc + 1;
        for (int l = 0; l < NL; l++) begin
            if (RST) begin
                m_last[l] = N - 1;
                m_next[l] = 0;
                exp_q[l].delete();
            end else if (cyc >= m_next[l] && req_a[l] != '0) begin
                pick = -1;
                for (int k = 1; k <= N; k++) begin
                    if (pick < 0 && req_a[l][(m_last[l] + k) % N]) pick = (m_last[l] + k) % N;
                end
                e.id   = pick;
                e.data = data_a[l][8*pick +: 8];
                e.at   = cyc;
                exp_q[l].push_back(e);
                m_last[l] = pick;
                m_next[l] = cyc + flen(l) * DIV + 1;
            end
        end
    end

    // Monitor: pops an expectation on each ACK and follows the whole frame.
    bit          act     [NL] = '{default: 1'b0};
    int          pos     [NL] = '{default: 0};
    int          mism    [NL] = '{default: 0};
    int          last_id [NL] = '{default: 0};
    logic [10:0] fb      [NL];

    always @(negedge CLK) begin
        exp_t e;
        for (int l = 0; l < NL; l++) begin
            if (RST) begin
                act[l]     = 1'b0;
                last_id[l] = 0;
            end else begin
                if (ack_a[l] != '0) begin
                    checks++;
                    if (act[l] || exp_q[l].size() == 0) begin
                        errors++;
                        $display("FAIL lane%0d stray_ack: ACK=%b active=%0d queued=%0d, required no ACK",
                                 l, ack_a[l], act[l], exp_q[l].size());
                    end else begin
                        e = exp_q[l].pop_front();
                        chk(l, "ack_vector", int'(ack_a[l]), 1 << e.id);
                        chk(l, "grant_id", int'(gid_a[l]), e.id);
                        chk(l, "grant_cycle", cyc, e.at);
                        act[l]     = 1'b1;
                        pos[l]     = 0;
                        mism[l]    = 0;
                        fb[l]      = frame_bits(l, e.data);
                        last_id[l] = e.id;
                    end
                end
                if (act[l]) begin
                    if (txd_a[l] !== fb[l][pos[l] / DIV]) mism[l]++;
                    if (busy_a[l] !== 1'b1) mism[l]++;
                    if (done_a[l] !== (pos[l] == flen(l) * DIV - 1)) mism[l]++;
                    pos[l]++;
                    if (pos[l] == flen(l) * DIV) begin
                        chk(l, "frame_clocks_bad", mism[l], 0);
                        act[l] = 1'b0;
                    end
                end else begin
                    chk(l, "idle_busy_done_txd", int'({busy_a[l], done_a[l], txd_a[l]}), 1);
                    chk(l, "idle_grant_hold", int'(gid_a[l]), last_id[l]);
                end
            end
        end
    end

    // Stimulus: requesters drop REQ on their ACK unless held.
    bit hold [N] = '{default: 1'b0};
    bit rnd_en = 1'b0;

    task automatic tick();
        @(posedge CLK);
        #2;
        for (int l = 0; l < NL; l++) begin
            for (int i = 0; i < N; i++) begin
                if (ack_a[l][i]) begin
                    if (hold[i]) begin
                        req_a[l][i] = 1'b1;
                    end else if (rnd_en && $urandom_range(0, 2) == 0) begin
                        data_a[l][8*i +: 8] = 8'($urandom);
                    end else begin
                        req_a[l][i] = 1'b0;
                    end
                end
            end
        end
        if (rnd_en) begin
            for (int l = 0; l < NL; l++) begin
                for (int i = 0; i < N; i++) begin
                    if (!req_a[l][i] && $urandom_range(0, 199) == 0) begin
                        req_a[l][i]         = 1'b1;
                        data_a[l][8*i +: 8] = 8'($urandom);
                    end
                end
            end
        end
    endtask

    task automatic raise(input int i, input logic [7:0] b);
        for (int l = 0; l < NL; l++) begin
            req_a[l][i]         = 1'b1;
            data_a[l][8*i +: 8] = b;
        end
    endtask

    task automatic clear_reqs();
        for (int l = 0; l < NL; l++) req_a[l] = '0;
    endtask

    function automatic bit all_quiet();
        for (int l = 0; l < NL; l++) begin
            if (req_a[l] != '0 || act[l] || busy_a[l] || exp_q[l].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_idle(input string tag);
        for (int n = 0; n < 20000; n++) begin
            tick();
            if (all_quiet()) return;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: lanes still busy after 20000 clocks, required idle", tag);
    endtask

    task automatic wait_ack(input int i);
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (ack_a[0][i]) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_ack%0d_timeout: no ACK within 3000 clocks, required one", i);
    endtask

    task automatic do_reset();
        tick();
        RST = 1'b1;
        clear_reqs();
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int l = 0; l < NL; l++) begin
            chk(l, {tag, "_txd"}, int'(txd_a[l]), 1);
            chk(l, {tag, "_busy"}, int'(busy_a[l]), 0);
            chk(l, {tag, "_ack"}, int'(ack_a[l]), 0);
            chk(l, {tag, "_frame_done"}, int'(done_a[l]), 0);
            chk(l, {tag, "_grant"}, int'(gid_a[l]), 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int l = 0; l < NL; l++) begin
            req_a[l]  = '0;
            data_a[l] = '0;
        end
        #1 RST = 1'b1;
        #1 check_reset_outputs("reset");
        tick();
        tick();
        RST = 1'b0;

        // Single frame of 0x41 from requester 0.
        raise(0, 8'h41);
        wait_idle("single");

        // All four at once after reset: strict rotation 0,1,2,3.
        do_reset();
        for (int i = 0; i < N; i++) raise(i, 8'(8'h10 + i));
        wait_idle("all_four");

        // Requester 0 held high; requester 2 joins mid-frame and must interleave.
        hold[0] = 1'b1;
        raise(0, 8'h55);
        wait_ack(0);
        repeat (40) tick();
        raise(2, 8'hA2);
        repeat (5 * 177) tick();
        hold[0] = 1'b0;
        wait_idle("held_req");

        // Byte of requester 1 changes after capture; the latched byte is sent.
        raise(1, 8'h3C);
        wait_ack(1);
        repeat (20) tick();
        for (int l = 0; l < NL; l++) data_a[l][15:8] = 8'hC3;
        wait_idle("data_change");

        // Parity variants on 0x07.
        raise(2, 8'h07);
        wait_idle("parity");

        // Reset inside data bit 3, then REQ=1010 must grant requester 1 first.
        raise(0, 8'h5A);
        wait_ack(0);
        repeat (4 * DIV + 3) tick();
        RST = 1'b1;
        #1 check_reset_outputs("midframe_reset");
        clear_reqs();
        raise(1, 8'h81);
        raise(3, 8'h83);
        tick();
        tick();
        RST = 1'b0;
        wait_idle("post_reset");

        // Randomised traffic with occasional re-requests after ACK.
        rnd_en = 1'b1;
        repeat (6000) tick();
        rnd_en = 1'b0;
        wait_idle("random");

        for (int l = 0; l < NL; l++) chk(l, "queue_drained", exp_q[l].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
